instr_reg_sched: RTL and testbench

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

---
 rtl/instr_register_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/instr_reg_sched.sv | 121 ++++++++++++
 tb/tb_instr_reg_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its scheduler front end.
package instr_register_pkg;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int IR_DEPTH = 32;

  // Occupancy counters must reach IR_DEPTH itself, hence one bit wider than address_t.
  typedef logic [5:0] count_t;

  typedef enum logic {RUN, DRAIN} sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester granted last loses the next tie.
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_prio1;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = ~r_prio1;
        o_gnt1 = r_prio1;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_prio1 <= 1'b0;
    else if (o_gnt0) r_prio1 <= 1'b1;
    else if (o_gnt1) r_prio1 <= 1'b0;
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Arbitrates two requesters into the 32-entry instruction register used as a circular FIFO.
//   state | meaning
//   RUN   | accept requests while not full, pops allowed
//   DRAIN | no acceptances, pops continue until alloc_cnt reaches 0
module instr_reg_sched
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  opcode_t      req0_opcode,
  input  operand_t     req0_operand_a,
  input  operand_t     req0_operand_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  opcode_t      req1_opcode,
  input  operand_t     req1_operand_a,
  input  operand_t     req1_operand_b,
  output logic         req1_ready,
  output logic         out_valid,
  output instruction_t out_instr,
  input  logic         out_ready,
  input  logic         drain_req,
  output logic         drain_done,
  output logic         load_en,
  output opcode_t      opcode,
  output operand_t     operand_a,
  output operand_t     operand_b,
  output address_t     write_pointer,
  output address_t     read_pointer,
  input  instruction_t instruction_word
);

  sched_state_t r_state, w_state_nxt;
  logic         w_done_nxt;
  address_t     r_wr_ptr, r_rd_ptr;
  count_t       r_alloc_cnt, r_commit_cnt;
  logic         w_arb_en, w_accept, w_pop;

  // reset_n gates the enable so readies drop the moment reset asserts.
  assign w_arb_en = reset_n && (r_state == RUN) && (r_alloc_cnt < count_t'(IR_DEPTH));

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req0  (req0_valid),
    .i_req1  (req1_valid),
    .i_en    (w_arb_en),
    .o_gnt0  (req0_ready),
    .o_gnt1  (req1_ready)
  );

  assign w_accept     = req0_ready | req1_ready;
  assign out_valid    = (r_commit_cnt != '0);
  assign w_pop        = out_valid && out_ready;
  assign out_instr    = instruction_word;
  assign read_pointer = r_rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      r_wr_ptr      <= '0;
    end else begin
      load_en <= w_accept;
      if (w_accept) begin
        write_pointer <= r_wr_ptr;
        r_wr_ptr      <= r_wr_ptr + 5'd1;
        if (req0_ready) begin
          opcode    <= req0_opcode;
          operand_a <= req0_operand_a;
          operand_b <= req0_operand_b;
        end else begin
          opcode    <= req1_opcode;
          operand_a <= req1_operand_a;
          operand_b <= req1_operand_b;
        end
      end
    end
  end

  // commit_cnt trails alloc_cnt by the one cycle the register needs to capture load_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr     <= '0;
      r_alloc_cnt  <= '0;
      r_commit_cnt <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 5'd1;
      r_alloc_cnt  <= r_alloc_cnt + count_t'(w_accept) - count_t'(w_pop);
      r_commit_cnt <= r_commit_cnt + count_t'(load_en) - count_t'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      RUN:   if (drain_req) w_state_nxt = DRAIN;
      DRAIN: if (r_alloc_cnt == '0) begin
        w_state_nxt = RUN;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      drain_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      drain_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural instruction register and FIFO scoreboard.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  opcode_t      req0_opcode, req1_opcode;
  operand_t     req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic         req0_ready, req1_ready;
  logic         out_valid, out_ready;
  instruction_t out_instr;
  logic         drain_req, drain_done;
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word;

  instruction_t mem [IR_DEPTH];
  instruction_t sb [$];
  int errors = 0;
  int checks = 0;
  int pops   = 0;

  always #5 clk = ~clk;

  instr_reg_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_operand_a(req0_operand_a),
    .req0_operand_b(req0_operand_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_operand_a(req1_operand_a),
    .req1_operand_b(req1_operand_b), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
    .drain_req(drain_req), .drain_done(drain_done),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word)
  );

  always @(posedge clk) if (load_en) mem[write_pointer] <= '{opcode, operand_a, operand_b};
  assign instruction_word = mem[read_pointer];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard sampling at the falling edge, then advance to just after the next rising edge.
  task automatic cyc();
    instruction_t e;
    @(negedge clk);
    if (req0_valid && req0_ready) sb.push_back('{req0_opcode, req0_operand_a, req0_operand_b});
    if (req1_valid && req1_ready) sb.push_back('{req1_opcode, req1_operand_a, req1_operand_b});
    if (out_valid && out_ready) begin
      pops++;
      if (sb.size() == 0) chk("pop_with_empty_sb", 72'(sb.size()), 72'd1);
      else begin
        e = sb.pop_front();
        chk("out_instr", 72'(out_instr), 72'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_all(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      cyc();
      n++;
    end
    out_ready = 1'b0;
    chk("sb_drained", 72'(sb.size()), 72'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1; drain_req = 1'b0;
    req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3;
    req1_opcode = SUB; req1_operand_a = 30; req1_operand_b = 40;
    #1;
    chk("rst_req0_ready", 72'(req0_ready), 72'd0);
    chk("rst_req1_ready", 72'(req1_ready), 72'd0);
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_load_en", 72'(load_en), 72'd0);
    chk("rst_write_pointer", 72'(write_pointer), 72'd0);
    chk("rst_read_pointer", 72'(read_pointer), 72'd0);
    chk("rst_drain_done", 72'(drain_done), 72'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    do_reset();

    // Single write
    req0_valid = 1'b1;
    #1;
    chk("single_req0_ready", 72'(req0_ready), 72'd1);
    chk("single_req1_ready", 72'(req1_ready), 72'd0);
    cyc();
    req0_valid = 1'b0;
    chk("single_load_en", 72'(load_en), 72'd1);
    chk("single_wp", 72'(write_pointer), 72'd0);
    chk("single_opcode", 72'(opcode), 72'(ADD));
    chk("single_out_valid_early", 72'(out_valid), 72'd0);
    cyc();
    chk("single_load_en_low", 72'(load_en), 72'd0);
    chk("single_out_valid", 72'(out_valid), 72'd1);
    chk("single_out_instr", 72'(out_instr), 72'({ADD, 32'sd5, 32'sd3}));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("single_out_valid_after_pop", 72'(out_valid), 72'd0);
    chk("single_rp", 72'(read_pointer), 72'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pop_on_empty_ignored_rp", 72'(read_pointer), 72'd1);

    // Contention from a fresh reset: grants alternate starting with requester 0
    do_reset();
    req0_opcode = ADD; req0_operand_a = 10; req0_operand_b = 20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_req0_ready", 72'(req0_ready), 72'(i % 2 == 0));
      chk("cont_req1_ready", 72'(req1_ready), 72'(i % 2 == 1));
      if (i > 0) chk("cont_wp", 72'(write_pointer), 72'(i - 1));
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_wp_last", 72'(write_pointer), 72'd3);
    pop_all(20);

    // Fill to 32, stall, pop one, wrap write to address 0
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < IR_DEPTH; i++) begin
      req0_opcode = opcode_t'(4'(i % 8)); req0_operand_a = i; req0_operand_b = 100 + i;
      #1;
      chk("fill_req0_ready", 72'(req0_ready), 72'd1);
      cyc();
    end
    req1_valid = 1'b1;
    #1;
    chk("full_req0_ready", 72'(req0_ready), 72'd0);
    chk("full_req1_ready", 72'(req1_ready), 72'd0);
    cyc();
    cyc();
    chk("full_req0_ready_hold", 72'(req0_ready), 72'd0);
    chk("full_out_valid", 72'(out_valid), 72'd1);
    req1_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    req0_opcode = SUB; req0_operand_a = 77; req0_operand_b = 88;
    #1;
    chk("wrap_req0_ready", 72'(req0_ready), 72'd1);
    cyc();
    req0_valid = 1'b0;
    chk("wrap_load_en", 72'(load_en), 72'd1);
    chk("wrap_wp", 72'(write_pointer), 72'd0);
    pop_all(80);

    // Simultaneous accept and pop with 5 committed entries (wr_ptr=rd_ptr=1 here)
    req0_valid = 1'b1; req0_opcode = PASSA;
    for (int i = 0; i < 5; i++) begin
      req0_operand_a = 200 + i;
      cyc();
    end
    req0_valid = 1'b0;
    cyc();
    cyc();
    req0_valid = 1'b1; req0_opcode = MULT; req0_operand_a = 9; req0_operand_b = 9;
    out_ready = 1'b1;
    #1;
    chk("sim_rp_before", 72'(read_pointer), 72'd1);
    chk("sim_req0_ready", 72'(req0_ready), 72'd1);
    cyc();
    req0_valid = 1'b0; out_ready = 1'b0;
    chk("sim_rp_after", 72'(read_pointer), 72'd2);
    chk("sim_wp", 72'(write_pointer), 72'd6);
    chk("sim_load_en", 72'(load_en), 72'd1);
    cyc();
    p0 = pops;
    pop_all(40);
    chk("sim_remaining_pops", 72'(pops - p0), 72'd5);
    chk("sim_empty", 72'(out_valid), 72'd0);

    // Drain with 3 stored entries
    req0_valid = 1'b1; req0_opcode = MOD;
    for (int i = 0; i < 3; i++) begin
      req0_operand_b = i;
      cyc();
    end
    req0_valid = 1'b0;
    cyc();
    cyc();
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    req0_valid = 1'b1; req0_opcode = DIV;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_req0_ready", 72'(req0_ready), 72'd0);
      chk("drain_done_early", 72'(drain_done), 72'd0);
      if (i == 1) drain_req = 1'b1;
      cyc();
      drain_req = 1'b0;
    end
    out_ready = 1'b0;
    chk("drain_empty_ready", 72'(req0_ready), 72'd0);
    chk("drain_done_not_yet", 72'(drain_done), 72'd0);
    cyc();
    chk("drain_done_pulse", 72'(drain_done), 72'd1);
    chk("drain_back_to_run", 72'(req0_ready), 72'd1);
    req0_valid = 1'b0;
    cyc();
    chk("drain_done_one_cycle", 72'(drain_done), 72'd0);
    chk("drain_sb_empty", 72'(sb.size()), 72'd0);

    // Drain request with nothing allocated
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("drain0_req0_ready", 72'(req0_ready), 72'd0);
    chk("drain0_done_low", 72'(drain_done), 72'd0);
    req0_valid = 1'b0;
    cyc();
    chk("drain0_done_pulse", 72'(drain_done), 72'd1);
    cyc();
    chk("drain0_done_clear", 72'(drain_done), 72'd0);

    // Reset asserted while load_en is high
    req0_valid = 1'b1; req0_opcode = DIV; req0_operand_a = 55; req0_operand_b = 66;
    cyc();
    chk("midrst_load_en_before", 72'(load_en), 72'd1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_load_en", 72'(load_en), 72'd0);
    chk("midrst_wp", 72'(write_pointer), 72'd0);
    chk("midrst_rp", 72'(read_pointer), 72'd0);
    chk("midrst_opcode", 72'(opcode), 72'(ZERO));
    chk("midrst_operand_a", 72'(operand_a), 72'd0);
    chk("midrst_operand_b", 72'(operand_b), 72'd0);
    chk("midrst_req0_ready", 72'(req0_ready), 72'd0);
    chk("midrst_out_valid", 72'(out_valid), 72'd0);
    chk("midrst_drain_done", 72'(drain_done), 72'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req0_valid = 1'b0;
    cyc();
    cyc();
    chk("postrst_out_valid", 72'(out_valid), 72'd0);
    chk("postrst_load_en", 72'(load_en), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
